// File: rtl/adder_pipe_pkg.sv
// Shared constants for the pipelined adder: default geometry,
// chunk-width helper and flag register bit positions.
package adder_pipe_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_STAGES  = 2;
  localparam int DEF_AUX_BIT = 4;

  localparam int FLAG_C  = 0;
  localparam int FLAG_AC = 1;
  localparam int FLAG_V  = 2;
  localparam int FLAG_Z  = 3;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One chunk of the pipelined adder: chunk add, stage register,
// valid bit and local ready. The last stage also forms ovf/zero/clamp.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STAGES  = DEF_STAGES,
  parameter int AUX_BIT = DEF_AUX_BIT,
  parameter int K       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_c,
  input  logic             in_ac,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_ac,
  output logic             out_sat,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int CW       = chunk_w(WIDTH, STAGES);
  localparam int LO       = K * CW;
  localparam bit LAST     = (K == STAGES - 1);
  localparam bit AUX_HERE = (AUX_BIT - 1 >= LO) &&
                            (AUX_BIT - 1 < LO + CW);
  localparam int AJ       = AUX_HERE ? AUX_BIT - LO : 0;

  logic [CW-1:0]    xc;
  logic [CW-1:0]    yc;
  logic [CW:0]      sum;
  logic [CW:0]      c;
  logic             ac_next;
  logic             ovf_next;
  logic [WIDTH-1:0] s_next;
  logic             load;

  assign xc  = in_x[LO +: CW];
  assign yc  = in_y[LO +: CW];
  assign sum = {1'b0, xc} + {1'b0, yc} + {{CW{1'b0}}, in_c};

  // Carry into bit i recovered as sum ^ x ^ y.
  always_comb begin
    c     = '0;
    c[0]  = in_c;
    for (int i = 1; i < CW; i++) begin
      c[i] = sum[i] ^ xc[i] ^ yc[i];
    end
    c[CW] = sum[CW];
  end

  generate
    if (AUX_HERE) begin : g_aux
      assign ac_next = c[AJ];
    end else begin : g_no_aux
      assign ac_next = in_ac;
    end
  endgenerate

  assign ovf_next = c[CW] ^ c[CW-1];

  always_comb begin
    s_next = in_s;
    s_next[LO +: CW] = sum[CW-1:0];
    if (LAST && in_sat && ovf_next) begin
      s_next = c[CW-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                       : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_s     <= '0;
      out_c     <= 1'b0;
      out_ac    <= 1'b0;
      out_sat   <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      if (in_ready) begin
        out_valid <= in_valid;
      end
      if (load) begin
        out_x    <= in_x;
        out_y    <= in_y;
        out_s    <= s_next;
        out_c    <= c[CW];
        out_ac   <= ac_next;
        out_sat  <= in_sat;
        out_ovf  <= LAST ? ovf_next : 1'b0;
        out_zero <= LAST ? (s_next == '0) : 1'b0;
      end
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder with valid/ready backpressure.
// Optional saturation on signed overflow: ADDER_PIPE_SAT_EN.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STAGES  = DEF_STAGES,
  parameter int AUX_BIT = DEF_AUX_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             x_inv,
  input  logic             y_inv,
`ifdef ADDER_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             acout,
  output logic             ovf,
  output logic             zero
);

  logic [STAGES:0]  v_a;
  logic [STAGES:0]  r_a;
  logic [WIDTH-1:0] x_a [0:STAGES];
  logic [WIDTH-1:0] y_a [0:STAGES];
  logic [WIDTH-1:0] s_a [0:STAGES];
  logic [STAGES:0]  c_a;
  logic [STAGES:0]  ac_a;
  logic [STAGES:0]  sat_a;
  logic [STAGES-1:0] ovf_a;
  logic [STAGES-1:0] zero_a;
  logic             unused_ok;

  assign v_a[0]   = in_valid;
  assign in_ready = r_a[0];
  assign x_a[0]   = x_inv ? ~x : x;
  assign y_a[0]   = y_inv ? ~y : y;
  assign s_a[0]   = '0;
  assign c_a[0]   = cin;
  assign ac_a[0]  = 1'b0;
`ifdef ADDER_PIPE_SAT_EN
  assign sat_a[0] = sat;
`else
  assign sat_a[0] = 1'b0;
`endif

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_pipe_stage #(
        .WIDTH   (WIDTH),
        .STAGES  (STAGES),
        .AUX_BIT (AUX_BIT),
        .K       (k)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v_a[k]),
        .in_ready  (r_a[k]),
        .in_x      (x_a[k]),
        .in_y      (y_a[k]),
        .in_s      (s_a[k]),
        .in_c      (c_a[k]),
        .in_ac     (ac_a[k]),
        .in_sat    (sat_a[k]),
        .out_valid (v_a[k+1]),
        .out_ready (r_a[k+1]),
        .out_x     (x_a[k+1]),
        .out_y     (y_a[k+1]),
        .out_s     (s_a[k+1]),
        .out_c     (c_a[k+1]),
        .out_ac    (ac_a[k+1]),
        .out_sat   (sat_a[k+1]),
        .out_ovf   (ovf_a[k]),
        .out_zero  (zero_a[k])
      );
    end
  endgenerate

  assign r_a[STAGES] = out_ready;
  assign out_valid   = v_a[STAGES];
  assign z           = s_a[STAGES];
  assign cout        = c_a[STAGES];
  assign acout       = ac_a[STAGES];
  assign ovf         = ovf_a[STAGES-1];
  assign zero        = zero_a[STAGES-1];

  // Operand copies and early-stage flags are dead past the last stage.
  assign unused_ok = ^{x_a[STAGES], y_a[STAGES], sat_a[STAGES],
                       ovf_a, zero_a};

endmodule
